weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader_pkg.sv | 28 ++
 rtl/weight_loader.sv | 152 +++++++++++++++
 tb/tb_weight_loader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/weight_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package : Config
// Brief   : Array geometry shared by the weight path, plus the weight loader
//           state encoding.
//           WLOAD_ZERO_PAD_EN (optional macro) adds the PAD state.
// Revision: 1.0 - initial release
// ============================================================================
package Config;

  // Systolic array geometry: columns, weight rows per column, weight width.
  localparam int sys_cols   = 3;
  localparam int W_rows     = 4;
  localparam int W_BITWIDTH = 8;

  // Weight loader states. PAD only exists when short tiles are zero-filled.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
`ifdef WLOAD_ZERO_PAD_EN
    ,
    PAD   = 2'd3
`endif
  } wload_state_t;

endpackage
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// Module  : weight_loader
// Brief   : Streams one weight tile (COLS*ROWS words) from a valid/ready
//           source into per-column weight buffers, column-major order.
//           Writes are registered (one cycle after accept); a full column
//           buffer stalls the stream. Tile length mismatches set sticky err.
// Macro   : WLOAD_ZERO_PAD_EN - when defined, an early s_last is followed by
//           zero words up to the end of the tile; otherwise the tile ends
//           right after the short word is written.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           start              - one-cycle tile load request (IDLE only)
//           s_valid/s_ready/s_data/s_last - upstream weight stream
//           buf_full[COLS]     - per-column buffer full flags
//           wr_en[COLS], wr_data[COLS][DW] - per-column buffer write port
//           busy, done, err    - status (done = one-cycle completion pulse)
// Revision: 1.0 - initial release
// ============================================================================
module weight_loader
  import Config::*;
#(
  parameter int COLS = sys_cols,
  parameter int ROWS = W_rows,
  parameter int DW   = W_BITWIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_last,
  input  logic [COLS-1:0]          buf_full,
  output logic [COLS-1:0]          wr_en,
  output logic [COLS-1:0][DW-1:0]  wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  wload_state_t             r_state;
  wload_state_t             w_state_nxt;
  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  // Set once the write of the tile's final slot has been launched; the FSM
  // then spends one more cycle in LOAD/PAD while that write is on the outputs.
  logic                     r_final;
  logic                     r_err;
  logic [COLS-1:0]          r_wr_en;
  logic [COLS-1:0][DW-1:0]  r_wr_data;

  logic w_full;
  logic w_at_end;
  logic w_ready;
  logic w_accept;
  logic w_pad_slot;
  logic w_slot;

  assign w_full   = buf_full[r_col];
  assign w_at_end = (r_col == CW'(COLS - 1)) && (r_row == RW'(ROWS - 1));
  assign w_ready  = (r_state == LOAD) && !r_final && !w_full;
  assign w_accept = w_ready && s_valid;

`ifdef WLOAD_ZERO_PAD_EN
  assign w_pad_slot = (r_state == PAD) && !r_final && !w_full;
`else
  assign w_pad_slot = 1'b0;
`endif

  // Any cycle that launches a buffer write (real word or zero pad).
  assign w_slot = w_accept || w_pad_slot;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (start) w_state_nxt = LOAD;
      LOAD: begin
        if (r_final) begin
          w_state_nxt = FLUSH;
`ifdef WLOAD_ZERO_PAD_EN
        end else if (w_accept && s_last && !w_at_end) begin
          w_state_nxt = PAD;
`endif
        end
      end
`ifdef WLOAD_ZERO_PAD_EN
      PAD:   if (r_final) w_state_nxt = FLUSH;
`endif
      FLUSH: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_final   <= 1'b0;
      r_err     <= 1'b0;
      r_wr_en   <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_en   <= '0;
      r_wr_data <= '0;

      if ((r_state == IDLE) && start) begin
        r_col   <= '0;
        r_row   <= '0;
        r_final <= 1'b0;
        r_err   <= 1'b0;
      end

      if (w_slot) begin
        r_wr_en[r_col]   <= 1'b1;
        r_wr_data[r_col] <= w_accept ? s_data : '0;
        if (w_at_end) begin
          r_final <= 1'b1;
        end else if (r_row == RW'(ROWS - 1)) begin
          r_row <= '0;
          r_col <= r_col + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end

      if (w_accept) begin
        // Mismatch: s_last on a non-final word, or final word without s_last.
        if (s_last != w_at_end) r_err <= 1'b1;
`ifndef WLOAD_ZERO_PAD_EN
        // Short tile: stop after this word's write.
        if (s_last) r_final <= 1'b1;
`endif
      end
    end
  end

  // Outputs are forced low for the whole time reset is held, including the
  // cycle it is first seen, so an abandoned tile never emits another write.
  assign s_ready = w_ready && !rst;
  assign busy    = (r_state != IDLE) && !rst;
  assign done    = (r_state == FLUSH) && !rst;
  assign err     = r_err && !rst;
  assign wr_en   = rst ? '0 : r_wr_en;
  assign wr_data = rst ? '0 : r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_weight_loader
// Brief   : Self-checking bench for weight_loader (COLS=3, ROWS=4, DW=8).
//           Directed tiles plus randomized tiles against a reference model
//           of the expected write sequence.
// Revision: 1.0 - initial release
// ============================================================================
module tb_weight_loader;
  import Config::*;

  localparam int COLS = 3;
  localparam int ROWS = 4;
  localparam int DW   = 8;
  localparam int T    = COLS * ROWS;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    s_valid;
  logic                    s_ready;
  logic [DW-1:0]           s_data;
  logic                    s_last;
  logic [COLS-1:0]         buf_full;
  logic [COLS-1:0]         wr_en;
  logic [COLS-1:0][DW-1:0] wr_data;
  logic                    busy;
  logic                    done;
  logic                    err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] words [0:T];
  int            got_col [$];
  logic [DW-1:0] got_dat [$];

  always #5 clk = ~clk;

  weight_loader #(.COLS(COLS), .ROWS(ROWS), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .buf_full(buf_full), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_wr_en"},   wr_en,   0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"},    busy,    0);
    check({tag, "_done"},    done,    0);
    check({tag, "_err"},     err,     0);
  endtask

  // Drive one tile and check it against the model.
  //   nwords     : words offered upstream
  //   last_idx   : index carrying s_last (-1 = never)
  //   vpct/fpct  : percent chance of s_valid / each buf_full bit per cycle
  //   mid_start  : cycle to re-pulse start during the load (-1 = none)
  //   full_*     : directed full window on one column when word full_from is next
  //   chk_lat    : check done latency after the last accept
  task automatic run_tile(input string name, input int nwords, input int last_idx,
                          input int vpct, input int fpct, input int mid_start,
                          input int full_col, input int full_from, input int full_len,
                          input bit chk_lat);
    int idx = 0, cyc = 0, acc_cyc = -1, done_cyc = -1, ndone = 0;
    int fw = 0, full_low = 0, acc_exp, npad, nexp;
    bit fstarted = 0;
    logic [COLS-1:0] prev_full = '0;
    int exp_col [$];
    logic [DW-1:0] exp_dat [$];
    got_col.delete();
    got_dat.delete();

    while (cyc < 400 && !(ndone > 0 && cyc > done_cyc + 2)) begin
      @(negedge clk);
      start   = (cyc == 0) || (cyc == mid_start);
      s_valid = (cyc > 0) && (idx < nwords) && ($urandom_range(99) < vpct);
      s_data  = (idx < nwords) ? words[idx] : '0;
      s_last  = (idx == last_idx);
      for (int c = 0; c < COLS; c++) buf_full[c] = ($urandom_range(99) < fpct);
      if (full_len > 0 && !fstarted && idx == full_from && cyc > 0) begin
        fstarted = 1;
        fw = full_len;
      end
      if (fw > 0) buf_full[full_col] = 1'b1;
      #1;
      if (fw > 0) begin
        fw--;
        if (!s_ready) full_low++;
        check({name, "_ready_while_full"}, s_ready, 0);
      end
      check({name, "_wr_en_onehot"}, ($countones(wr_en) <= 1), 1);
      for (int c = 0; c < COLS; c++) begin
        if (wr_en[c]) begin
          got_col.push_back(c);
          got_dat.push_back(wr_data[c]);
          check({name, "_write_to_full"}, prev_full[c], 0);
        end else begin
          check({name, "_idle_col_data_zero"}, wr_data[c], 0);
        end
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (s_valid && s_ready) begin
        idx++;
        acc_cyc = cyc;
      end
      prev_full = buf_full;
      cyc++;
    end
    start = 0; s_valid = 0; s_last = 0; buf_full = '0;

    // Reference model: words land column-major; a short tile stops (or is
    // zero-padded), an overlong tile stops at T words.
    acc_exp = (last_idx >= 0 && last_idx < T - 1) ? last_idx + 1 : T;
    for (int i = 0; i < acc_exp; i++) begin
      exp_col.push_back(i / ROWS);
      exp_dat.push_back(words[i]);
    end
    npad = 0;
`ifdef WLOAD_ZERO_PAD_EN
    for (int i = acc_exp; i < T; i++) begin
      exp_col.push_back(i / ROWS);
      exp_dat.push_back('0);
      npad++;
    end
`endif
    check({name, "_accepted"}, idx, acc_exp);
    check({name, "_done_pulses"}, ndone, 1);
    check({name, "_err"}, err, (last_idx != T - 1));
    check({name, "_busy_after"}, busy, 0);
    nexp = exp_col.size();
    check({name, "_n_writes"}, got_col.size(), nexp);
    for (int i = 0; i < nexp && i < got_col.size(); i++) begin
      check({name, "_wr_col"}, got_col[i], exp_col[i]);
      check({name, "_wr_data"}, got_dat[i], exp_dat[i]);
    end
    if (chk_lat) check({name, "_done_latency"}, done_cyc - acc_cyc, 2 + npad);
    if (full_len > 0) check({name, "_full_low_cycles"}, full_low, full_len);
  endtask

  task automatic seq_words();
    for (int i = 0; i <= T; i++) words[i] = DW'(i + 1);
  endtask

  initial begin
    rst = 1; start = 0; s_valid = 0; s_data = '0; s_last = 0; buf_full = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 0;

    // Basic full tile, back-to-back words.
    seq_words();
    run_tile("basic", T, T - 1, 100, 0, -1, 0, 0, 0, 1);

    // Column 1 full for 5 cycles while its first word (word 5) is next.
    run_tile("colfull", T, T - 1, 100, 0, -1, 1, 4, 5, 1);

    // Early s_last on word 7.
    run_tile("short7", T, 6, 100, 0, -1, 0, 0, 0, 1);

    // Reset pulsed after word 3, then a clean tile.
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1; s_data = words[k];
      #1;
      check("rst_mid_ready", s_ready, 1);
      @(negedge clk);
    end
    s_valid = 0;
    rst = 1;
    #1;
    check_all_zero("rst_mid_during");
    @(negedge clk);
    rst = 0;
    #1;
    check_all_zero("rst_mid_after");
    for (int i = 0; i <= T; i++) words[i] = DW'(8'hA0 + i);
    run_tile("after_rst", T, T - 1, 100, 0, -1, 0, 0, 0, 1);

    // Overlong tile with a start pulse during LOAD.
    seq_words();
    run_tile("overlong", T + 1, -1, 100, 0, 5, 0, 0, 0, 1);

    // Randomized tiles.
    for (int t = 0; t < 25; t++) begin
      int kind, last, n, vp, fp;
      for (int i = 0; i <= T; i++) words[i] = DW'($urandom);
      kind = $urandom_range(2);
      vp = $urandom_range(40, 100);
      fp = $urandom_range(0, 30);
      if (kind == 0) begin
        last = T - 1; n = T;
      end else if (kind == 1) begin
        last = $urandom_range(0, T - 2); n = T;
      end else begin
        last = -1; n = T + 1;
      end
      run_tile("rand", n, last, vp, fp, -1, 0, 0, 0, (fp == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
